// File: rtl/utf16_encoder_if.sv
// utf16_encoder_if: code point in / UTF-16 unit out handshake bundle
interface utf16_encoder_if;
  logic        allow;
  logic [20:0] code_point;
  logic        ready;
  logic [15:0] unit;
  logic        unit_valid;
  logic        unit_ack;
  logic [1:0]  status;
  modport master (output allow, code_point, unit_ack, input ready, unit, unit_valid, status);
  modport slave (input allow, code_point, unit_ack, output ready, unit, unit_valid, status);
endinterface

// File: rtl/utf16_encoder.sv
// utf16_encoder: code point -> UTF-16 units (BMP or surrogate pair); optional BOM via UTF16_ENCODER_BOM_EN
module utf16_encoder #(
  parameter bit REPLACE_INVALID = 1'b0,
  parameter bit SWAP_BYTES      = 1'b0
) (
  input logic            i_clock,
  input logic            i_reset_n,
  utf16_encoder_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SINGLE, S_HIGH, S_LOW, S_ERR
`ifdef UTF16_ENCODER_BOM_EN
    , S_BOM
`endif
  } state_t;
  state_t      r_state, w_next, w_cls_st, w_acc_st;
  logic        r_live, r_done;
  logic [15:0] r_unit, w_cls_unit;
  logic [9:0]  r_low;
  logic [19:0] w_v;
  logic        w_bmp, w_supp, w_fin, w_ready, w_accept, w_valid;
`ifdef UTF16_ENCODER_BOM_EN
  logic        r_bom_done;
  state_t      r_pend_st;
  logic [15:0] r_pend_unit;
`endif
  always_comb begin
    w_v        = bus.code_point[19:0] - 20'h10000;
    w_bmp      = bus.code_point <= 21'h00FFFF && bus.code_point[15:11] != 5'b11011;
    w_supp     = bus.code_point >= 21'h010000 && bus.code_point <= 21'h10FFFF;
    w_cls_st   = w_bmp ? S_SINGLE : w_supp ? S_HIGH : REPLACE_INVALID ? S_SINGLE : S_ERR;
    w_cls_unit = w_bmp ? bus.code_point[15:0] : w_supp ? {6'b110110, w_v[19:10]} : 16'hFFFD;
`ifdef UTF16_ENCODER_BOM_EN
    w_acc_st   = (!r_bom_done && w_cls_st != S_ERR) ? S_BOM : w_cls_st;
`else
    w_acc_st   = w_cls_st;
`endif
    w_fin      = (r_state == S_SINGLE || r_state == S_LOW) && bus.unit_ack;
    // r_live keeps ready low until the first edge after reset release
    w_ready    = r_live && (r_state == S_IDLE || w_fin);
    w_accept   = bus.allow && w_ready;
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_SINGLE, S_LOW: w_next = w_accept ? w_acc_st : w_fin ? S_IDLE : r_state;
      S_HIGH:                  w_next = bus.unit_ack ? S_LOW : S_HIGH;
`ifdef UTF16_ENCODER_BOM_EN
      S_BOM:                   w_next = bus.unit_ack ? r_pend_st : S_BOM;
`endif
      default:                 w_next = r_state;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_live      <= 1'b0;
      r_done      <= 1'b0;
      r_unit      <= '0;
      r_low       <= '0;
`ifdef UTF16_ENCODER_BOM_EN
      r_bom_done  <= 1'b0;
      r_pend_st   <= S_IDLE;
      r_pend_unit <= '0;
`endif
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_done      <= 1'b1;
        r_low       <= w_v[9:0];
`ifdef UTF16_ENCODER_BOM_EN
        r_bom_done  <= 1'b1;
        r_pend_st   <= w_cls_st;
        r_pend_unit <= w_cls_unit;
        r_unit      <= (w_acc_st == S_BOM) ? 16'hFEFF : w_cls_unit;
`else
        r_unit      <= w_cls_unit;
`endif
      end else if (r_state == S_HIGH && bus.unit_ack) r_unit <= {6'b110111, r_low};
`ifdef UTF16_ENCODER_BOM_EN
      else if (r_state == S_BOM && bus.unit_ack) r_unit <= r_pend_unit;
`endif
    end
  always_comb begin
    w_valid        = r_state != S_IDLE && r_state != S_ERR;
    bus.unit_valid = w_valid;
    bus.ready      = w_ready;
    bus.unit       = !w_valid ? 16'h0 : SWAP_BYTES ? {r_unit[7:0], r_unit[15:8]} : r_unit;
    bus.status     = r_state == S_ERR ? 2'd3 : w_valid ? 2'd1 : r_done ? 2'd2 : 2'd0;
  end
endmodule

// File: tb/tb_utf16_encoder.sv
// tb_utf16_encoder: directed checks on three encoder configurations
module tb_utf16_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  utf16_encoder_if b0 ();
  utf16_encoder_if b1 ();
  utf16_encoder_if b2 ();
  utf16_encoder #(.REPLACE_INVALID(1'b0), .SWAP_BYTES(1'b0)) dut0 (.i_clock(clk), .i_reset_n(rst_n), .bus(b0));
  utf16_encoder #(.REPLACE_INVALID(1'b1), .SWAP_BYTES(1'b0)) dut1 (.i_clock(clk), .i_reset_n(rst_n), .bus(b1));
  utf16_encoder #(.REPLACE_INVALID(1'b0), .SWAP_BYTES(1'b1)) dut2 (.i_clock(clk), .i_reset_n(rst_n), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b0.allow = 0; b0.code_point = '0; b0.unit_ack = 0;
    b1.allow = 0; b1.code_point = '0; b1.unit_ack = 0;
    b2.allow = 0; b2.code_point = '0; b2.unit_ack = 0;
    rst_n = 0;
    tick(); tick();
    checks++; if (b0.unit !== 16'h0) begin errors++; $display("FAIL rst_unit got %h want 0000", b0.unit); end
    checks++; if (b0.unit_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", b0.unit_valid); end
    checks++; if (b0.status !== 2'd0) begin errors++; $display("FAIL rst_status got %0d want 0", b0.status); end
    checks++; if (b0.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", b0.ready); end
    rst_n = 1;
    tick();
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", b0.ready); end
    checks++; if (b0.status !== 2'd0) begin errors++; $display("FAIL rel_status got %0d want 0", b0.status); end
  endtask

  task automatic test_bmp();
    b0.allow = 1; b0.code_point = 21'h000041; b0.unit_ack = 1;
    tick();
`ifdef UTF16_ENCODER_BOM_EN
    checks++; if (b0.unit !== 16'hFEFF) begin errors++; $display("FAIL bmp_bom got %h want feff", b0.unit); end
    b0.allow = 0;
    tick();
`endif
    checks++; if (b0.unit !== 16'h0041) begin errors++; $display("FAIL bmp_unit got %h want 0041", b0.unit); end
    checks++; if (b0.unit_valid !== 1'b1) begin errors++; $display("FAIL bmp_valid got %b want 1", b0.unit_valid); end
    checks++; if (b0.status !== 2'd1) begin errors++; $display("FAIL bmp_status got %0d want 1", b0.status); end
    b0.allow = 0;
    tick();
    checks++; if (b0.unit_valid !== 1'b0) begin errors++; $display("FAIL bmp_done_valid got %b want 0", b0.unit_valid); end
    checks++; if (b0.status !== 2'd2) begin errors++; $display("FAIL bmp_done_status got %0d want 2", b0.status); end
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL bmp_done_ready got %b want 1", b0.ready); end
  endtask

  task automatic test_pair();
    b0.allow = 1; b0.code_point = 21'h01F600; b0.unit_ack = 1;
    tick();
    checks++; if (b0.unit !== 16'hD83D) begin errors++; $display("FAIL pair_high got %h want d83d", b0.unit); end
    checks++; if (b0.ready !== 1'b0) begin errors++; $display("FAIL pair_high_ready got %b want 0", b0.ready); end
    b0.allow = 0;
    tick();
    checks++; if (b0.unit !== 16'hDE00) begin errors++; $display("FAIL pair_low got %h want de00", b0.unit); end
    checks++; if (b0.unit_valid !== 1'b1) begin errors++; $display("FAIL pair_low_valid got %b want 1", b0.unit_valid); end
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL pair_low_ready got %b want 1", b0.ready); end
    tick();
    checks++; if (b0.status !== 2'd2) begin errors++; $display("FAIL pair_done_status got %0d want 2", b0.status); end
  endtask

  task automatic test_backpressure();
    b0.allow = 1; b0.code_point = 21'h0020AC; b0.unit_ack = 0;
    tick();
    checks++; if (b0.unit !== 16'h20AC) begin errors++; $display("FAIL bp_unit got %h want 20ac", b0.unit); end
    b0.code_point = 21'h000041;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (b0.unit !== 16'h20AC) begin errors++; $display("FAIL bp_hold_unit got %h want 20ac", b0.unit); end
      checks++; if (b0.unit_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", b0.unit_valid); end
      checks++; if (b0.ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %b want 0", b0.ready); end
    end
    b0.allow = 0; b0.unit_ack = 1;
    tick();
    checks++; if (b0.unit_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b want 0", b0.unit_valid); end
    checks++; if (b0.status !== 2'd2) begin errors++; $display("FAIL bp_done_status got %0d want 2", b0.status); end
  endtask

  task automatic test_back_to_back();
    b0.allow = 1; b0.unit_ack = 1;
    b0.code_point = 21'h000048; tick();
    checks++; if (b0.unit !== 16'h0048) begin errors++; $display("FAIL b2b_0 got %h want 0048", b0.unit); end
    b0.code_point = 21'h000069; tick();
    checks++; if (b0.unit !== 16'h0069) begin errors++; $display("FAIL b2b_1 got %h want 0069", b0.unit); end
    b0.code_point = 21'h000021; tick();
    checks++; if (b0.unit !== 16'h0021) begin errors++; $display("FAIL b2b_2 got %h want 0021", b0.unit); end
    b0.code_point = 21'h01F600; tick();
    checks++; if (b0.unit !== 16'hD83D) begin errors++; $display("FAIL b2b_high got %h want d83d", b0.unit); end
    b0.code_point = 21'h000042; tick();
    checks++; if (b0.unit !== 16'hDE00) begin errors++; $display("FAIL b2b_low got %h want de00", b0.unit); end
    tick();
    checks++; if (b0.unit !== 16'h0042) begin errors++; $display("FAIL b2b_after_pair got %h want 0042", b0.unit); end
    b0.allow = 0; tick();
    checks++; if (b0.unit_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", b0.unit_valid); end
    tick(); tick();
    checks++; if (b0.status !== 2'd2) begin errors++; $display("FAIL idle_ack_status got %0d want 2", b0.status); end
  endtask

  task automatic test_error();
    b0.allow = 1; b0.code_point = 21'h00D800; b0.unit_ack = 1;
    tick();
    checks++; if (b0.status !== 2'd3) begin errors++; $display("FAIL err_status got %0d want 3", b0.status); end
    checks++; if (b0.unit_valid !== 1'b0) begin errors++; $display("FAIL err_valid got %b want 0", b0.unit_valid); end
    checks++; if (b0.unit !== 16'h0) begin errors++; $display("FAIL err_unit got %h want 0000", b0.unit); end
    b0.code_point = 21'h000041;
    tick(); tick(); tick();
    checks++; if (b0.status !== 2'd3) begin errors++; $display("FAIL err_sticky got %0d want 3", b0.status); end
    checks++; if (b0.ready !== 1'b0) begin errors++; $display("FAIL err_ready got %b want 0", b0.ready); end
    b0.allow = 0;
    rst_n = 0;
    #1;
    checks++; if (b0.status !== 2'd0) begin errors++; $display("FAIL err_async_rst got %0d want 0", b0.status); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (b0.status !== 2'd0) begin errors++; $display("FAIL err_rel_status got %0d want 0", b0.status); end
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL err_rel_ready got %b want 1", b0.ready); end
    b0.allow = 1; b0.code_point = 21'h110000;
    tick();
    checks++; if (b0.status !== 2'd3) begin errors++; $display("FAIL err_big_status got %0d want 3", b0.status); end
    b0.allow = 0;
  endtask

  task automatic test_replace();
    b1.allow = 1; b1.code_point = 21'h110000; b1.unit_ack = 1;
    tick();
`ifdef UTF16_ENCODER_BOM_EN
    checks++; if (b1.unit !== 16'hFEFF) begin errors++; $display("FAIL rep_bom got %h want feff", b1.unit); end
    tick();
`endif
    checks++; if (b1.unit !== 16'hFFFD) begin errors++; $display("FAIL rep_big got %h want fffd", b1.unit); end
    checks++; if (b1.status !== 2'd1) begin errors++; $display("FAIL rep_status got %0d want 1", b1.status); end
    b1.code_point = 21'h00DFFF; tick();
    checks++; if (b1.unit !== 16'hFFFD) begin errors++; $display("FAIL rep_surr got %h want fffd", b1.unit); end
    b1.allow = 0; tick();
    checks++; if (b1.status !== 2'd2) begin errors++; $display("FAIL rep_done_status got %0d want 2", b1.status); end
  endtask

  task automatic test_swap_and_reset_pair();
    b2.allow = 1; b2.code_point = 21'h0000E9; b2.unit_ack = 1;
    tick();
`ifdef UTF16_ENCODER_BOM_EN
    checks++; if (b2.unit !== 16'hFFFE) begin errors++; $display("FAIL swap_bom got %h want fffe", b2.unit); end
    checks++; if (b2.ready !== 1'b0) begin errors++; $display("FAIL swap_bom_ready got %b want 0", b2.ready); end
    b2.allow = 0;
    tick();
`endif
    checks++; if (b2.unit !== 16'hE900) begin errors++; $display("FAIL swap_e9 got %h want e900", b2.unit); end
    b2.allow = 0; tick();
    checks++; if (b2.unit_valid !== 1'b0) begin errors++; $display("FAIL swap_done_valid got %b want 0", b2.unit_valid); end
    b2.allow = 1; b2.code_point = 21'h01F600; b2.unit_ack = 0;
    tick();
    checks++; if (b2.unit !== 16'h3DD8) begin errors++; $display("FAIL swap_high got %h want 3dd8", b2.unit); end
    b2.allow = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1; b2.unit_ack = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (b2.unit_valid !== 1'b0) begin errors++; $display("FAIL midpair_valid got %b want 0", b2.unit_valid); end
    end
    b2.allow = 1; b2.code_point = 21'h000041;
    tick();
`ifdef UTF16_ENCODER_BOM_EN
    checks++; if (b2.unit !== 16'hFFFE) begin errors++; $display("FAIL swap_bom2 got %h want fffe", b2.unit); end
    b2.allow = 0;
    tick();
`endif
    checks++; if (b2.unit !== 16'h4100) begin errors++; $display("FAIL swap_41 got %h want 4100", b2.unit); end
    b2.allow = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bmp();
    test_pair();
    test_backpressure();
    test_back_to_back();
    test_error();
    test_replace();
    test_swap_and_reset_pair();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
